// File: rtl/mac_sequencer_if.sv
// Instruction channel between the issuing controller and mac_sequencer.
// The master drives the instruction and its operands; the slave returns inst_ready.
interface mac_sequencer_if #(
  parameter int unsigned BRAM_ADDRESS_WIDTH = 12,
  parameter int unsigned MAX_IFMAP_CNT_W    = 16
);
  logic                          inst_valid;
  logic [31:0]                   inst;
  logic [MAX_IFMAP_CNT_W-1:0]    inst_arg;
  logic                          inst_ready;
  logic [4:0]                    kernel_size;
  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr;

  modport master (
    output inst_valid, inst, inst_arg, kernel_size, weight_base_addr,
    input  inst_ready
  );

  modport slave (
    input  inst_valid, inst, inst_arg, kernel_size, weight_base_addr,
    output inst_ready
  );
endinterface

// File: rtl/mac_sequencer.sv
// Instruction sequencer for the MAC array: weight fetch/load, ifmap load and pooling.
// Define MAC_SEQ_POOL_EN to accept the pooling opcode (89); otherwise it is illegal.
module mac_sequencer #(
  parameter int unsigned BRAM_ADDRESS_WIDTH = 12,
  parameter int unsigned MAX_IFMAP_CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mac_sequencer_if.slave                inst_if,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  output logic                          bram_rd_en,
  output logic                          load_weight_preload,
  output logic                          load_MAC_weight,
  output logic                          load_ifmaps,
  output logic                          pooling_compute,
  input  logic                          ifmaps_fifo_empty,
  output logic                          busy,
  output logic                          done,
  output logic                          illegal_inst
);

  localparam int unsigned AW    = BRAM_ADDRESS_WIDTH;
  localparam int unsigned CNT_W = MAX_IFMAP_CNT_W;

  localparam logic [31:0] OP_COMPUTE = 32'd87;
  localparam logic [31:0] OP_IFMAPS  = 32'd88;
  localparam logic [31:0] OP_POOL    = 32'd89;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_READ  = 3'd1;
  localparam logic [2:0] S_W_DRAIN = 3'd2;
  localparam logic [2:0] S_W_LOAD  = 3'd3;
  localparam logic [2:0] S_IF_LOAD = 3'd4;
  localparam logic [2:0] S_POOL    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             ill_q, ill_d;

  logic             rd_en_q, rd_en_d;
  logic             preload_q;
  logic             load_mac_q, load_mac_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             pool_q, pool_d;

  logic             accept_c;
  logic             ks_legal_c;
  logic             if_beat_c;

  assign accept_c   = inst_if.inst_valid && (state_q == S_IDLE);
  assign ks_legal_c = (inst_if.kernel_size != 5'd0) && (inst_if.kernel_size <= 5'd5);
  assign if_beat_c  = (state_q == S_IF_LOAD) && !ifmaps_fifo_empty;

  // Next-state, counter/address and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ill_d      = ill_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          // Operands are captured here; later changes on the bus are ignored
          if (inst_if.inst == OP_COMPUTE && ks_legal_c) begin
            state_d = S_W_READ;
            cnt_d   = CNT_W'(inst_if.kernel_size);
            addr_d  = inst_if.weight_base_addr;
          end else if (inst_if.inst == OP_IFMAPS) begin
            cnt_d   = inst_if.inst_arg;
            state_d = (inst_if.inst_arg == '0) ? S_DONE : S_IF_LOAD;
`ifdef MAC_SEQ_POOL_EN
          end else if (inst_if.inst == OP_POOL) begin
            state_d = S_POOL;
`endif
          end else begin
            ill_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_W_READ: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_W_DRAIN;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          addr_d = addr_q + AW'(1);
        end
      end
      S_W_DRAIN: state_d = S_W_LOAD;
      S_W_LOAD:  state_d = S_DONE;
      S_IF_LOAD: begin
        // Stalls without limit while the FIFO is empty
        if (if_beat_c) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_POOL:    state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    rd_en_d    = (state_d == S_W_READ);
    load_mac_d = (state_d == S_W_LOAD);
    pool_d     = (state_d == S_POOL);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
    ready_d    = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ill_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      preload_q  <= 1'b0;
      load_mac_q <= 1'b0;
      pool_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ill_q      <= ill_d;
      rd_en_q    <= rd_en_d;
      // One-cycle BRAM read latency: preload shift follows the read strobe
      preload_q  <= rd_en_q;
      load_mac_q <= load_mac_d;
      pool_q     <= pool_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign inst_if.inst_ready  = ready_q;
  assign bram_addr           = addr_q;
  assign bram_rd_en          = rd_en_q;
  assign load_weight_preload = preload_q;
  assign load_MAC_weight     = load_mac_q;
  // Follows the FIFO within the cycle so an empty FIFO never produces a beat
  assign load_ifmaps         = if_beat_c;
  assign busy                = busy_q;
  assign done                = done_q;
  assign illegal_inst        = ill_q;

`ifdef MAC_SEQ_POOL_EN
  assign pooling_compute     = pool_q;
`else
  assign pooling_compute     = 1'b0;
  logic unused_pool;
  assign unused_pool         = pool_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised and directed bench for mac_sequencer against a per-instruction trace model.
module tb_mac_sequencer;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 16;
`ifdef MAC_SEQ_POOL_EN
  localparam bit POOL_EN = 1'b1;
`else
  localparam bit POOL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] bram_addr;
  logic          bram_rd_en, load_weight_preload, load_MAC_weight, load_ifmaps;
  logic          pooling_compute, ifmaps_fifo_empty, busy, done, illegal_inst;

  always #5 clk = ~clk;

  mac_sequencer_if #(.BRAM_ADDRESS_WIDTH(AW), .MAX_IFMAP_CNT_W(CW)) inst_if ();

  mac_sequencer #(.BRAM_ADDRESS_WIDTH(AW), .MAX_IFMAP_CNT_W(CW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .inst_if             (inst_if.slave),
    .bram_addr           (bram_addr),
    .bram_rd_en          (bram_rd_en),
    .load_weight_preload (load_weight_preload),
    .load_MAC_weight     (load_MAC_weight),
    .load_ifmaps         (load_ifmaps),
    .pooling_compute     (pooling_compute),
    .ifmaps_fifo_empty   (ifmaps_fifo_empty),
    .busy                (busy),
    .done                (done),
    .illegal_inst        (illegal_inst)
  );

  int checks = 0;
  int errors = 0;

  // Expected per-cycle output vector: {rd, preload, mac, ifmaps, pool, done, busy, ready, illegal}
  logic [8:0]    exp_sig[$];
  logic [AW-1:0] exp_addr[$];
  bit            exp_empty[$];
  bit            exp_ill = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obs_vec();
    return {bram_rd_en, load_weight_preload, load_MAC_weight, load_ifmaps,
            pooling_compute, done, busy, inst_if.inst_ready, illegal_inst};
  endfunction

  function automatic logic [8:0] idle_vec();
    return {7'b0, 1'b1, exp_ill};
  endfunction

  task automatic push(input bit rd, input bit pre, input bit mac, input bit ld,
                      input bit pool, input bit dn, input logic [AW-1:0] a, input bit e);
    exp_sig.push_back({rd, pre, mac, ld, pool, dn, 1'b1, 1'b0, exp_ill});
    exp_addr.push_back(a);
    exp_empty.push_back(e);
  endtask

  // Expected trace, cycle 1 being the cycle after the accepting edge
  task automatic build(input logic [31:0] op, input logic [4:0] ks, input logic [AW-1:0] base,
                       input logic [CW-1:0] arg, input bit directed);
    int rem;
    bit e;
    exp_sig.delete(); exp_addr.delete(); exp_empty.delete();
    if (op == 32'd87 && ks >= 5'd1 && ks <= 5'd5) begin
      for (int c = 1; c <= int'(ks) + 3; c++)
        push(c <= int'(ks), c >= 2 && c <= int'(ks) + 1, c == int'(ks) + 2, 1'b0, 1'b0,
             c == int'(ks) + 3, base + AW'(c - 1), 1'($urandom_range(0, 1)));
    end else if (op == 32'd88 && arg != '0) begin
      rem = int'(arg);
      for (int c = 1; c < 200; c++) begin
        e = directed ? (c >= 3 && c <= 5) : ($urandom_range(0, 2) == 0);
        if (rem > 0) begin
          push(1'b0, 1'b0, 1'b0, !e, 1'b0, 1'b0, '0, e);
          if (!e) rem--;
        end else begin
          push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, e);
          break;
        end
      end
    end else if (op == 32'd89 && POOL_EN) begin
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    end else begin
      if (op != 32'd88) exp_ill = 1'b1;
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'($urandom_range(0, 1)));
    end
  endtask

  // Issue one instruction and check every cycle; abort > 0 stops after that many cycles
  task automatic run(input string tag, input logic [31:0] op, input logic [4:0] ks,
                     input logic [AW-1:0] base, input logic [CW-1:0] arg,
                     input bit directed, input int abort);
    int pulses = 0;
    build(op, ks, base, arg, directed);
    inst_if.inst             = op;
    inst_if.kernel_size      = ks;
    inst_if.weight_base_addr = base;
    inst_if.inst_arg         = arg;
    inst_if.inst_valid       = 1'b1;
    @(posedge clk);
    for (int c = 0; c < exp_sig.size(); c++) begin
      @(negedge clk);
      inst_if.inst_valid       = 1'b0;
      inst_if.inst             = $urandom;
      inst_if.kernel_size      = 5'($urandom);
      inst_if.weight_base_addr = AW'($urandom);
      inst_if.inst_arg         = CW'($urandom);
      ifmaps_fifo_empty        = exp_empty[c];
      #1;
      chk($sformatf("%s.c%0d.sig", tag, c + 1), 32'(obs_vec()), 32'(exp_sig[c]));
      if (exp_sig[c][8]) chk($sformatf("%s.c%0d.addr", tag, c + 1), 32'(bram_addr), 32'(exp_addr[c]));
      if (load_ifmaps) pulses++;
      if (abort > 0 && c + 1 == abort) return;
    end
    if (op == 32'd88) chk({tag, ".ifmap_pulses"}, 32'(pulses), 32'(arg));
    @(negedge clk);
    ifmaps_fifo_empty = 1'($urandom_range(0, 1));
    #1;
    chk({tag, ".idle"}, 32'(obs_vec()), 32'(idle_vec()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] op;
    rst_n                    = 1'b0;
    inst_if.inst_valid       = 1'b0;
    inst_if.inst             = '0;
    inst_if.inst_arg         = '0;
    inst_if.kernel_size      = '0;
    inst_if.weight_base_addr = '0;
    ifmaps_fifo_empty        = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.sig", 32'(obs_vec()), 32'(idle_vec()));
    chk("reset.addr", 32'(bram_addr), 32'd0);
    rst_n = 1'b1;

    run("k3_base010", 32'd87, 5'd3, 12'h010, '0, 1'b0, 0);
    run("k2_wrap", 32'd87, 5'd2, 12'hFFF, '0, 1'b0, 0);
    run("k5", 32'd87, 5'd5, 12'h7FE, '0, 1'b0, 0);
    run("k1", 32'd87, 5'd1, 12'h3A5, '0, 1'b0, 0);
    run("if4_stall", 32'd88, 5'd0, '0, 16'd4, 1'b1, 0);
    run("if0", 32'd88, 5'd2, '0, 16'd0, 1'b0, 0);
    run("pool", 32'd89, 5'd1, '0, '0, 1'b0, 0);
    run("k0_illegal", 32'd87, 5'd0, 12'h010, '0, 1'b0, 0);
    run("k6_illegal", 32'd87, 5'd6, 12'h010, '0, 1'b0, 0);
    run("op99_illegal", 32'd99, 5'd3, 12'h010, '0, 1'b0, 0);
    run("k3_after_ill", 32'd87, 5'd3, 12'h100, '0, 1'b0, 0);

    // Reset in the middle of W_READ: strobes drop at once and no done follows
    run("k5_abort", 32'd87, 5'd5, 12'h123, '0, 1'b0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    exp_ill = 1'b0;
    #1;
    chk("midrst.sig", 32'(obs_vec()), 32'(idle_vec()));
    chk("midrst.addr", 32'(bram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst.release", 32'(obs_vec()), 32'(idle_vec()));
    run("if3_after_rst", 32'd88, 5'd0, '0, 16'd3, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = 32'd87;
        2:       op = 32'd88;
        3:       op = 32'd89;
        default: op = $urandom;
      endcase
      run($sformatf("rnd%0d", i), op, 5'($urandom_range(0, 6)), AW'($urandom),
          CW'($urandom_range(0, 6)), 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
